// File: rtl/spectrum_frame_gen_pkg.sv
// Shared constants and types for the spectrum frame generator.
package spectrum_frame_gen_pkg;

   localparam int unsigned SFG_NFFT_LOG2 = 10;
   localparam int unsigned SFG_N         = 1 << SFG_NFFT_LOG2;
   localparam int unsigned SFG_DW        = 24;

   localparam logic signed [SFG_DW-1:0] SFG_MAX = {1'b0, {(SFG_DW-1){1'b1}}};
   localparam logic signed [SFG_DW-1:0] SFG_MIN = {1'b1, {(SFG_DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/spectrum_frame_gen_sat_add.sv
// Saturating add of two signed values, each optionally negated (saturating) first.
module spec_sat_add
   import spectrum_frame_gen_pkg::*;
#(
   parameter int unsigned DW = SFG_DW
) (
   input  logic signed [DW-1:0] a_i,
   input  logic signed [DW-1:0] b_i,
   input  logic                 neg_a_i,
   input  logic                 neg_b_i,
   output logic signed [DW-1:0] sum_o
);

   localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

   function automatic logic signed [DW-1:0] sat_neg(input logic signed [DW-1:0] v);
      return (v == MINV) ? MAXV : -v;
   endfunction

   logic signed [DW-1:0] a_s;
   logic signed [DW-1:0] b_s;
   logic signed [DW:0]   wide;

   // Negate operands on request, add one bit wider, clamp on overflow.
   always_comb begin
      a_s  = neg_a_i ? sat_neg(a_i) : a_i;
      b_s  = neg_b_i ? sat_neg(b_i) : b_i;
      wide = {a_s[DW-1], a_s} + {b_s[DW-1], b_s};
      unique case (wide[DW -: 2])
         2'b01:   sum_o = MAXV;
         2'b10:   sum_o = MINV;
         default: sum_o = wide[DW-1:0];
      endcase
   end

endmodule

// File: rtl/spectrum_frame_gen.sv
// Builds a Hermitian-symmetric spectrum frame from two tones and streams it over AXI-Stream.
module spectrum_frame_gen
   import spectrum_frame_gen_pkg::*;
#(
   parameter int unsigned NFFT_LOG2 = SFG_NFFT_LOG2,
   parameter int unsigned DW        = SFG_DW
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [NFFT_LOG2-1:0]  cfg_bin0,
   input  logic signed [DW-1:0]  cfg_re0,
   input  logic signed [DW-1:0]  cfg_im0,
   input  logic                  cfg_en1,
   input  logic [NFFT_LOG2-1:0]  cfg_bin1,
   input  logic signed [DW-1:0]  cfg_re1,
   input  logic signed [DW-1:0]  cfg_im1,
   output logic [2*DW-1:0]       m_axis_data_tdata,
   output logic                  m_axis_data_tvalid,
   input  logic                  m_axis_data_tready,
   output logic                  m_axis_data_tlast,
   output logic [15:0]           m_axis_data_tuser,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned          NPTS     = 1 << NFFT_LOG2;
   localparam logic [NFFT_LOG2-1:0] HALF_BIN = NFFT_LOG2'(NPTS / 2);
   localparam logic [NFFT_LOG2-1:0] LAST_IDX = NFFT_LOG2'(NPTS - 1);

   state_e                 state_q, state_d;
   logic [NFFT_LOG2-1:0]   idx_q, idx_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q, tlast_d;
   logic [2*DW-1:0]        tdata_q, tdata_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   ready_q, ready_d;
   logic [NFFT_LOG2-1:0]   bin0_q, bin0_d, bin1_q, bin1_d;
   logic signed [DW-1:0]   re0_q, re0_d, im0_q, im0_d, re1_q, re1_d, im1_q, im1_d;
   logic                   en1_q, en1_d;

   logic [NFFT_LOG2-1:0]   s_idx, s_bin0, s_bin1;
   logic signed [DW-1:0]   s_re0, s_im0, s_re1, s_im1;
   logic                   s_en1;
   logic                   edge0, edge1, hit0, hit1, cj0, cj1;
   logic signed [DW-1:0]   c_re0, c_im0, c_re1, c_im1;
   logic signed [DW-1:0]   sum_re_c, sum_im_c;

   // Tone source: live cfg for index 0 on acceptance, latched copy for the next index while streaming.
   always_comb begin
      if (state_q == IDLE) begin
         s_idx  = '0;
         s_bin0 = cfg_bin0;
         s_re0  = cfg_re0;
         s_im0  = cfg_im0;
         s_en1  = cfg_en1;
         s_bin1 = cfg_bin1;
         s_re1  = cfg_re1;
         s_im1  = cfg_im1;
      end else begin
         s_idx  = idx_q + NFFT_LOG2'(1);
         s_bin0 = bin0_q;
         s_re0  = re0_q;
         s_im0  = im0_q;
         s_en1  = en1_q;
         s_bin1 = bin1_q;
         s_re1  = re1_q;
         s_im1  = im1_q;
      end
   end

   // Bin match: direct hit at bin, conjugate at N-bin; DC and Nyquist bins are real-only.
   always_comb begin
      edge0 = (s_bin0 == '0) || (s_bin0 == HALF_BIN);
      edge1 = (s_bin1 == '0) || (s_bin1 == HALF_BIN);
      hit0  = (s_idx == s_bin0);
      hit1  = s_en1 && (s_idx == s_bin1);
      cj0   = !edge0 && (s_idx == NFFT_LOG2'(NPTS - 32'(s_bin0)));
      cj1   = s_en1 && !edge1 && (s_idx == NFFT_LOG2'(NPTS - 32'(s_bin1)));
      c_re0 = (hit0 || cj0) ? s_re0 : '0;
      c_im0 = (cj0 || (hit0 && !edge0)) ? s_im0 : '0;
      c_re1 = (hit1 || cj1) ? s_re1 : '0;
      c_im1 = (cj1 || (hit1 && !edge1)) ? s_im1 : '0;
   end

   spec_sat_add #(.DW(DW)) u_add_re (
      .a_i     (c_re0),
      .b_i     (c_re1),
      .neg_a_i (1'b0),
      .neg_b_i (1'b0),
      .sum_o   (sum_re_c)
   );

   spec_sat_add #(.DW(DW)) u_add_im (
      .a_i     (c_im0),
      .b_i     (c_im1),
      .neg_a_i (cj0),
      .neg_b_i (cj1),
      .sum_o   (sum_im_c)
   );

   // Next-state: accept descriptor in IDLE, advance index on handshake, pulse done.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tdata_d  = tdata_q;
      bin0_d   = bin0_q;
      re0_d    = re0_q;
      im0_d    = im0_q;
      en1_d    = en1_q;
      bin1_d   = bin1_q;
      re1_d    = re1_q;
      im1_d    = im1_q;
      unique case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               bin0_d   = cfg_bin0;
               re0_d    = cfg_re0;
               im0_d    = cfg_im0;
               en1_d    = cfg_en1;
               bin1_d   = cfg_bin1;
               re1_d    = cfg_re1;
               im1_d    = cfg_im1;
               idx_d    = '0;
               tvalid_d = 1'b1;
               tlast_d  = 1'b0;
               tdata_d  = {sum_im_c, sum_re_c};
               state_d  = STREAM;
            end
         end
         STREAM: begin
            if (tvalid_q && m_axis_data_tready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d    = '0;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  tdata_d  = '0;
                  state_d  = DONE;
               end else begin
                  idx_d   = s_idx;
                  tlast_d = (s_idx == LAST_IDX);
                  tdata_d = {sum_im_c, sum_re_c};
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d == STREAM);
      done_d  = (state_d == DONE);
      ready_d = (state_d == IDLE);
   end

   // State, descriptor latch and output register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         bin0_q   <= '0;
         re0_q    <= '0;
         im0_q    <= '0;
         en1_q    <= 1'b0;
         bin1_q   <= '0;
         re1_q    <= '0;
         im1_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
         bin0_q   <= bin0_d;
         re0_q    <= re0_d;
         im0_q    <= im0_d;
         en1_q    <= en1_d;
         bin1_q   <= bin1_d;
         re1_q    <= re1_d;
         im1_q    <= im1_d;
      end
   end

   assign cfg_ready          = ready_q;
   assign busy               = busy_q;
   assign frame_done         = done_q;
   assign m_axis_data_tvalid = tvalid_q;
   assign m_axis_data_tlast  = tlast_q;
   assign m_axis_data_tdata  = tdata_q;
   assign m_axis_data_tuser  = 16'(idx_q);

endmodule

// File: tb/tb_spectrum_frame_gen.sv
// Self-checking bench: scoreboard of expected beats per frame, directed frame sequence.
module tb_spectrum_frame_gen;
   import spectrum_frame_gen_pkg::*;

   localparam int unsigned NL = SFG_NFFT_LOG2;
   localparam int unsigned DW = SFG_DW;
   localparam int unsigned N  = SFG_N;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [NL-1:0]        cfg_bin0, cfg_bin1;
   logic signed [DW-1:0] cfg_re0, cfg_im0, cfg_re1, cfg_im1;
   logic                 cfg_en1;
   logic [2*DW-1:0]      m_axis_data_tdata;
   logic                 m_axis_data_tvalid;
   logic                 m_axis_data_tready;
   logic                 m_axis_data_tlast;
   logic [15:0]          m_axis_data_tuser;
   logic                 busy;
   logic                 frame_done;

   typedef struct {
      int bin0; int re0; int im0; bit en1; int bin1; int re1; int im1;
   } cfg_t;

   typedef struct packed {
      logic [15:0]     user;
      logic [2*DW-1:0] data;
      logic            last;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   always #10 clk = ~clk;

   spectrum_frame_gen dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .cfg_valid          (cfg_valid),
      .cfg_ready          (cfg_ready),
      .cfg_bin0           (cfg_bin0),
      .cfg_re0            (cfg_re0),
      .cfg_im0            (cfg_im0),
      .cfg_en1            (cfg_en1),
      .cfg_bin1           (cfg_bin1),
      .cfg_re1            (cfg_re1),
      .cfg_im1            (cfg_im1),
      .m_axis_data_tdata  (m_axis_data_tdata),
      .m_axis_data_tvalid (m_axis_data_tvalid),
      .m_axis_data_tready (m_axis_data_tready),
      .m_axis_data_tlast  (m_axis_data_tlast),
      .m_axis_data_tuser  (m_axis_data_tuser),
      .busy               (busy),
      .frame_done         (frame_done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic longint sat(input longint v);
      if (v > longint'(SFG_MAX)) return longint'(SFG_MAX);
      if (v < longint'(SFG_MIN)) return longint'(SFG_MIN);
      return v;
   endfunction

   // Reference sample value at index idx for descriptor c.
   function automatic logic [2*DW-1:0] model(input int idx, input cfg_t c);
      longint re = 0;
      longint im = 0;
      int b[2];
      int r[2];
      int i[2];
      b[0] = c.bin0; r[0] = c.re0; i[0] = c.im0;
      b[1] = c.bin1; r[1] = c.re1; i[1] = c.im1;
      for (int t = 0; t < 2; t++) begin
         if (t == 1 && !c.en1) continue;
         if (idx == b[t]) begin
            re += r[t];
            if (b[t] != 0 && b[t] != int'(N / 2)) im += i[t];
         end else if (b[t] != 0 && b[t] != int'(N / 2) && idx == (int'(N) - b[t]) % int'(N)) begin
            re += r[t];
            im += (i[t] == -8388608) ? 64'sd8388607 : -longint'(i[t]);
         end
      end
      re = sat(re);
      im = sat(im);
      return {im[DW-1:0], re[DW-1:0]};
   endfunction

   task automatic run_frame(input string name, input cfg_t c, input bit bp, input int abort_at);
      int              hs = 0;
      int              cyc = 0;
      int              waitc = 0;
      bit              stalled = 1'b0;
      bit              finished = 1'b0;
      logic [2*DW-1:0] p_data = '0;
      logic [15:0]     p_user = '0;
      logic            p_last = 1'b0;
      exp_t            e;
      while (cfg_ready !== 1'b1 && waitc < 10) begin
         @(posedge clk); #1;
         waitc++;
      end
      check({name, " cfg_ready_idle"}, 64'(cfg_ready), 64'(1));
      cfg_bin0 = NL'(c.bin0);  cfg_re0 = DW'(c.re0);  cfg_im0 = DW'(c.im0);
      cfg_en1  = c.en1;
      cfg_bin1 = NL'(c.bin1);  cfg_re1 = DW'(c.re1);  cfg_im1 = DW'(c.im1);
      cfg_valid = 1'b1;
      for (int n = 0; n < int'(N); n++) begin
         e.user = 16'(n);
         e.data = model(n, c);
         e.last = (n == int'(N) - 1);
         sb_q.push_back(e);
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      cfg_bin0  = NL'(c.bin0 + 1);
      cfg_re0   = '1;
      cfg_im1   = '1;
      while (!finished && cyc < int'(4 * N)) begin
         if (abort_at >= 0 && hs == abort_at) begin
            reset_n = 1'b0;
            cfg_valid = 1'b0;
            @(posedge clk); #1;
            check({name, " rst_tvalid"}, 64'(m_axis_data_tvalid), 64'(0));
            check({name, " rst_tlast"},  64'(m_axis_data_tlast),  64'(0));
            check({name, " rst_tdata"},  64'(m_axis_data_tdata),  64'(0));
            check({name, " rst_tuser"},  64'(m_axis_data_tuser),  64'(0));
            check({name, " rst_busy"},   64'(busy),               64'(0));
            check({name, " rst_done"},   64'(frame_done),         64'(0));
            check({name, " rst_ready"},  64'(cfg_ready),          64'(1));
            reset_n = 1'b1;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk); #1;
               check({name, " no_frame_done"}, 64'(frame_done), 64'(0));
            end
            sb_q.delete();
            return;
         end
         m_axis_data_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         cfg_valid          = bp ? 1'($urandom_range(0, 1)) : 1'b0;
         check({name, " busy"},      64'(busy),               64'(1));
         check({name, " cfg_ready"}, 64'(cfg_ready),          64'(0));
         check({name, " tvalid"},    64'(m_axis_data_tvalid), 64'(1));
         if (stalled) begin
            check({name, " stall_tdata"}, 64'(m_axis_data_tdata), 64'(p_data));
            check({name, " stall_tuser"}, 64'(m_axis_data_tuser), 64'(p_user));
            check({name, " stall_tlast"}, 64'(m_axis_data_tlast), 64'(p_last));
         end
         if (m_axis_data_tready && m_axis_data_tvalid) begin
            check({name, " sb_nonempty"}, 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check({name, " tuser"}, 64'(m_axis_data_tuser), 64'(e.user));
               check({name, " tdata"}, 64'(m_axis_data_tdata), 64'(e.data));
               check({name, " tlast"}, 64'(m_axis_data_tlast), 64'(e.last));
               if (e.last) finished = 1'b1;
            end
            hs++;
         end
         stalled = !m_axis_data_tready;
         p_data  = m_axis_data_tdata;
         p_user  = m_axis_data_tuser;
         p_last  = m_axis_data_tlast;
         @(posedge clk); #1;
         cyc++;
      end
      cfg_valid = 1'b0;
      check({name, " frame_finished"}, 64'(finished), 64'(1));
      check({name, " beats"}, 64'(hs), 64'(N));
      if (!bp) check({name, " cycles"}, 64'(cyc), 64'(N));
      check({name, " end_tvalid"}, 64'(m_axis_data_tvalid), 64'(0));
      check({name, " end_done"},   64'(frame_done),         64'(1));
      check({name, " end_ready"},  64'(cfg_ready),          64'(0));
      check({name, " end_busy"},   64'(busy),               64'(0));
      @(posedge clk); #1;
      check({name, " post_done"},  64'(frame_done), 64'(0));
      check({name, " post_ready"}, 64'(cfg_ready),  64'(1));
      check({name, " sb_drained"}, 64'(sb_q.size()), 64'(0));
      sb_q.delete();
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      cfg_valid = 1'b0;
      m_axis_data_tready = 1'b0;
      cfg_bin0 = '0; cfg_re0 = '0; cfg_im0 = '0;
      cfg_en1  = 1'b0;
      cfg_bin1 = '0; cfg_re1 = '0; cfg_im1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset tvalid", 64'(m_axis_data_tvalid), 64'(0));
      check("reset tlast",  64'(m_axis_data_tlast),  64'(0));
      check("reset tdata",  64'(m_axis_data_tdata),  64'(0));
      check("reset tuser",  64'(m_axis_data_tuser),  64'(0));
      check("reset busy",   64'(busy),               64'(0));
      check("reset done",   64'(frame_done),         64'(0));
      check("reset ready",  64'(cfg_ready),          64'(1));
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("idle ready",  64'(cfg_ready),          64'(1));
      check("idle tvalid", 64'(m_axis_data_tvalid), 64'(0));

      run_frame("tone5",   '{5, 1000, 200, 1'b0, 0, 0, 0}, 1'b0, -1);
      run_frame("dc",      '{0, 500, 77, 1'b0, 0, 0, 0}, 1'b0, -1);
      run_frame("nyq",     '{512, 500, 77, 1'b0, 0, 0, 0}, 1'b0, -1);
      run_frame("collide", '{10, 8388607, 100, 1'b1, 1014, 8388607, 40}, 1'b0, -1);
      run_frame("conjsat", '{3, 1234, -8388608, 1'b0, 0, 0, 0}, 1'b0, -1);
      run_frame("bp",      '{7, -3000, 4500, 1'b1, 700, 25000, -12345}, 1'b1, -1);
      run_frame("abort",   '{100, 2222, -333, 1'b1, 512, -4444, 99}, 1'b0, 300);
      run_frame("restart", '{1, -8388608, 8388607, 1'b1, 1023, -8388608, 5}, 1'b1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
